scoreboard_unit: RTL

Producer-side companion to the forwarding units. It tracks in-flight register writes from issue (ID→EX) to retirement (WB write), and raises a decode stall when forwarding cannot cover a dependency (load-use). It also keeps per-register pending counts so the hazard and interrupt logic can see whether the register file holds the architectural value. It sits beside the ID/EX pipeline register, is fed by decode and WB, and drives the PC/IF-ID write enables and the ID/EX bubble mux.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/sb_counter.sv | 41 ++++
 rtl/scoreboard_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the register scoreboard: register index, EX-shadow entry,
// and the load-use stall FSM states.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned NUM_REGS  = 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Snapshot of the instruction currently occupying EX.
    typedef struct packed {
        logic     valid;
        logic     is_load;
        logic     wr1;
        logic     wr2;
        reg_idx_t d1;
        reg_idx_t d2;
    } shadow_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } sb_state_e;

    // True when register r is one of the enabled destinations of entry s.
    function automatic logic dest_hit(input shadow_t s, input reg_idx_t r);
        return (s.wr1 && (s.d1 == r)) || (s.wr2 && (s.d2 == r));
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Single saturating up/down pending counter. Increment is 0/1 and decrement
// is 0..2 per cycle; the net change is applied with a floor of 0 and a
// ceiling of 2^CNT_W-1. ovf_out pulses when a net increment hits the ceiling.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_in,
    input  logic [1:0]       dec_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] sum;

    // Net update: two guard bits catch both underflow (sign) and overflow.
    always_comb begin
        sum     = {2'b00, cnt_q} + (CNT_W+2)'(inc_in) - (CNT_W+2)'(dec_in);
        cnt_d   = cnt_q;
        ovf_out = 1'b0;
        if (sum[CNT_W+1]) begin
            cnt_d = '0;
        end else if (sum[CNT_W]) begin
            cnt_d   = '1;
            ovf_out = 1'b1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/scoreboard_unit.sv
// Register scoreboard: per-register pending-write counters from issue to
// retirement, an EX shadow of the last issued instruction, and a one-cycle
// load-use stall FSM.
// Optional: SCOREBOARD_STATS_EN adds stall_cycles_out (wrapping stall count).
module scoreboard_unit #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_in,
    input  logic [2:0]          Rsrc_ID_in,
    input  logic [2:0]          Rdst_ID_in,
    input  logic                use_Rsrc_ID_in,
    input  logic                use_Rdst_ID_in,
    input  logic                wr1_ID_in,
    input  logic                wr2_ID_in,
    input  logic                mem_to_Reg_ID_in,
    input  logic                flush_EX_in,
    input  logic                wb_valid_in,
    input  logic [2:0]          Rdst1_WB_in,
    input  logic [2:0]          Rdst2_WB_in,
    input  logic                wr1_WB_in,
    input  logic                wr2_WB_in,
    output logic                stall_out,
    output logic [NUM_REGS-1:0] pending_mask_out,
    output logic                overflow_out
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]         stall_cycles_out
`endif
);

    import pipeline_pkg::*;

    shadow_t          shadow_q, shadow_d;
    sb_state_e        state_q, state_d;
    logic             overflow_q, overflow_d;
    logic             hz;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] ovf;
    logic [1:0]          dec [NUM_REGS];
    logic [CNT_W-1:0]    cnt [NUM_REGS];

    // Per-register increment/decrement decode; duplicate indices in one
    // source collapse to a single step, flush and retire each add one step.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue_valid_in &&
                     ((wr1_ID_in && (Rdst_ID_in == reg_idx_t'(r))) ||
                      (wr2_ID_in && (Rsrc_ID_in == reg_idx_t'(r))));
            dec[r] = {1'b0, wb_valid_in &&
                            ((wr1_WB_in && (Rdst1_WB_in == reg_idx_t'(r))) ||
                             (wr2_WB_in && (Rdst2_WB_in == reg_idx_t'(r))))}
                   + {1'b0, flush_EX_in && shadow_q.valid &&
                            dest_hit(shadow_q, reg_idx_t'(r))};
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_in  (inc[g]),
            .dec_in  (dec[g]),
            .cnt_out (cnt[g]),
            .ovf_out (ovf[g])
        );
        assign pending_mask_out[g] = |cnt[g];
    end

    // Load-use hazard against the instruction in EX, and shadow next value.
    always_comb begin
        hz = shadow_q.valid && shadow_q.is_load && !flush_EX_in &&
             ((use_Rsrc_ID_in && dest_hit(shadow_q, Rsrc_ID_in)) ||
              (use_Rdst_ID_in && dest_hit(shadow_q, Rdst_ID_in)));
        shadow_d       = shadow_q;
        shadow_d.valid = 1'b0;
        if (issue_valid_in) begin
            shadow_d.valid   = 1'b1;
            shadow_d.is_load = mem_to_Reg_ID_in;
            shadow_d.wr1     = wr1_ID_in;
            shadow_d.wr2     = wr2_ID_in;
            shadow_d.d1      = Rdst_ID_in;
            shadow_d.d2      = Rsrc_ID_in;
        end
        overflow_d = overflow_q | (|ovf);
    end

    // Stall FSM: stall in RUN on a hazard, then one BUBBLE cycle that never stalls.
    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        case (state_q)
            RUN: begin
                stall_out = hz;
                if (hz) state_d = BUBBLE;
            end
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Shadow, FSM and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            state_q    <= RUN;
            overflow_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_out = overflow_q;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // Stall cycle counter, wraps at 16 bits.
    always_comb begin
        stall_cycles_d = stall_cycles_q + 16'(stall_out);
    end

    // Stall cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_out = stall_cycles_q;
`endif

endmodule
